// File: rtl/lmk61e2_config_seq.sv
// Power-up/on-demand programming sequencer for the LMK61E2 synthesizer.
// Walks LUT entries 1..NUM_ENTRIES, issuing one I2C transfer per entry with NACK retries.
module lmk61e2_config_seq #(
   parameter int unsigned NUM_ENTRIES  = 2,
   parameter logic [6:0]  SLAVE_ADDR   = 7'h58,
   parameter logic [15:0] PWRUP_CYCLES = 16'd50000,
   parameter int unsigned MAX_RETRIES  = 2
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       start,
   input  logic [7:0] divider_in,
   output logic [3:0] lut_index,
   output logic [7:0] lut_divider,
   input  logic       lut_rw,
   input  logic [7:0] lut_address,
   input  logic [7:0] lut_data,
   output logic       i2c_req,
   input  logic       i2c_ack,
   input  logic       i2c_done,
   input  logic       i2c_nack,
   output logic [6:0] i2c_slave_addr,
   output logic       i2c_rw,
   output logic [7:0] i2c_reg_addr,
   output logic [7:0] i2c_wdata,
   output logic       busy,
   output logic       done,
   output logic       error,
   output logic [3:0] err_index
);

   typedef enum logic [2:0] {PWRUP, IDLE, LOAD, REQ, WAIT, NEXT, FAIL} state_t;

   localparam logic [3:0] LAST_IDX = 4'(NUM_ENTRIES);
   localparam logic [3:0] MAX_RTY  = 4'(MAX_RETRIES);

   state_t      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [3:0]  idx_q, idx_d;
   logic [7:0]  div_q, div_d;
   logic [3:0]  rty_q, rty_d;
   logic        rw_q, rw_d;
   logic [7:0]  addr_q, addr_d;
   logic [7:0]  wdata_q, wdata_d;
   logic        done_q, done_d;
   logic        error_q, error_d;
   logic [3:0]  erri_q, erri_d;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= PWRUP;
         cnt_q   <= '0;
         idx_q   <= '0;
         div_q   <= '0;
         rty_q   <= '0;
         rw_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         done_q  <= 1'b0;
         error_q <= 1'b0;
         erri_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         div_q   <= div_d;
         rty_q   <= rty_d;
         rw_q    <= rw_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         done_q  <= done_d;
         error_q <= error_d;
         erri_q  <= erri_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      div_d   = div_q;
      rty_d   = rty_q;
      rw_d    = rw_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      done_d  = done_q;
      error_d = error_q;
      erri_d  = erri_q;
      case (state_q)
         PWRUP: begin
            if (cnt_q == PWRUP_CYCLES - 16'd1) begin
               div_d   = divider_in;
               idx_d   = 4'd1;
               state_d = LOAD;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         IDLE: begin
            if (start) begin
               div_d   = divider_in;
               idx_d   = 4'd1;
               rty_d   = '0;
               done_d  = 1'b0;
               error_d = 1'b0;
               state_d = LOAD;
            end
         end
         LOAD: begin
            rw_d    = lut_rw;
            addr_d  = lut_address;
            wdata_d = lut_data;
            state_d = REQ;
         end
         REQ: begin
            if (i2c_ack) state_d = WAIT;
         end
         WAIT: begin
            if (i2c_done) begin
               if (!i2c_nack) begin
                  state_d = NEXT;
               end else if (rty_q < MAX_RTY) begin
                  rty_d   = rty_q + 4'd1;
                  state_d = REQ;
               end else begin
                  error_d = 1'b1;
                  erri_d  = idx_q;
                  state_d = FAIL;
               end
            end
         end
         NEXT: begin
            if (idx_q == LAST_IDX) begin
               done_d  = 1'b1;
               state_d = IDLE;
            end else begin
               idx_d   = idx_q + 4'd1;
               rty_d   = '0;
               state_d = LOAD;
            end
         end
         FAIL:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Request is decoded from the registered state, so reset drops it asynchronously.
   assign i2c_req        = (state_q == REQ);
   assign busy           = (state_q != IDLE);
   assign lut_index      = idx_q;
   assign lut_divider    = div_q;
   assign i2c_slave_addr = SLAVE_ADDR;
   assign i2c_rw         = rw_q;
   assign i2c_reg_addr   = addr_q;
   assign i2c_wdata      = wdata_q;
   assign done           = done_q;
   assign error          = error_q;
   assign err_index      = erri_q;

endmodule

// File: tb/tb_lmk61e2_config_seq.sv
// Bench for lmk61e2_config_seq: LUT and I2C master models plus a transfer-list reference.
module tb_lmk61e2_config_seq;

   localparam int unsigned N    = 2;
   localparam int unsigned MAXR = 2;

   logic       clk = 1'b0;
   logic       reset_n, start;
   logic [7:0] divider_in;
   logic [3:0] lut_index;
   logic [7:0] lut_divider;
   logic       lut_rw;
   logic [7:0] lut_address, lut_data;
   logic       i2c_req, i2c_ack, i2c_done, i2c_nack;
   logic [6:0] i2c_slave_addr;
   logic       i2c_rw;
   logic [7:0] i2c_reg_addr, i2c_wdata;
   logic       busy, done, error;
   logic [3:0] err_index;

   int checks = 0;
   int failures = 0;

   lmk61e2_config_seq #(
      .NUM_ENTRIES (N),
      .SLAVE_ADDR  (7'h58),
      .PWRUP_CYCLES(16'd10),
      .MAX_RETRIES (MAXR)
   ) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .divider_in(divider_in),
      .lut_index(lut_index), .lut_divider(lut_divider), .lut_rw(lut_rw),
      .lut_address(lut_address), .lut_data(lut_data), .i2c_req(i2c_req),
      .i2c_ack(i2c_ack), .i2c_done(i2c_done), .i2c_nack(i2c_nack),
      .i2c_slave_addr(i2c_slave_addr), .i2c_rw(i2c_rw), .i2c_reg_addr(i2c_reg_addr),
      .i2c_wdata(i2c_wdata), .busy(busy), .done(done), .error(error), .err_index(err_index)
   );

   always #5 clk = ~clk;

   // Register table: entry 1 fixed, entry 2 carries the output divider.
   always_comb begin
      lut_rw      = 1'b0;
      lut_address = 8'h00;
      lut_data    = 8'h00;
      case (lut_index)
         4'd1: begin lut_address = 8'h15; lut_data = 8'h02; end
         4'd2: begin lut_address = 8'h17; lut_data = lut_divider; end
         default: ;
      endcase
   end

   // I2C master: random ack and completion latency, NACKs drawn from nack_left per index.
   logic [16:0] log_q[$];
   int          nack_left[16];
   bit          hold = 1'b0;

   initial begin : master
      int          idx;
      logic [16:0] ent;
      i2c_ack = 1'b0; i2c_done = 1'b0; i2c_nack = 1'b0;
      for (int i = 0; i < 16; i++) nack_left[i] = 0;
      forever begin
         @(negedge clk);
         if (reset_n && i2c_req && !hold) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            idx = int'(lut_index);
            ent = {i2c_rw, i2c_reg_addr, i2c_wdata};
            i2c_ack = 1'b1;
            @(negedge clk);
            i2c_ack = 1'b0;
            repeat ($urandom_range(0, 3)) @(negedge clk);
            i2c_nack = (nack_left[idx] > 0);
            if (i2c_nack) nack_left[idx]--;
            i2c_done = 1'b1;
            log_q.push_back(ent);
            @(negedge clk);
            i2c_done = 1'b0;
            i2c_nack = 1'b0;
         end
      end
   end

   // Reference: expected transfer list for one pass given a NACK plan.
   int          nk_plan[16];
   logic [16:0] exp_q[$];
   int          exp_fail;

   function automatic logic [16:0] entry_of(int e, logic [7:0] div);
      if (e == 1) return {1'b0, 8'h15, 8'h02};
      return {1'b0, 8'h17, div};
   endfunction

   function automatic void build_expected(logic [7:0] div);
      int attempts;
      exp_q.delete();
      exp_fail = 0;
      for (int e = 1; e <= int'(N); e++) begin
         attempts = (nk_plan[e] > int'(MAXR)) ? int'(MAXR) + 1 : nk_plan[e] + 1;
         for (int a = 0; a < attempts; a++) exp_q.push_back(entry_of(e, div));
         if (nk_plan[e] > int'(MAXR)) begin
            exp_fail = e;
            break;
         end
      end
   endfunction

   function automatic void clear_plan();
      for (int i = 0; i < 16; i++) nk_plan[i] = 0;
   endfunction

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_idle(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (!busy) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      checks++; if (lut_index !== 4'd0) begin failures++; $display("FAIL rst_lut_index got=%0d exp=0", lut_index); end
      checks++; if (lut_divider !== 8'd0) begin failures++; $display("FAIL rst_lut_divider got=%0d exp=0", lut_divider); end
      checks++; if (i2c_req !== 1'b0) begin failures++; $display("FAIL rst_req got=%b exp=0", i2c_req); end
      checks++; if ({i2c_rw, i2c_reg_addr, i2c_wdata} !== 17'd0) begin failures++; $display("FAIL rst_i2c_regs got=%h exp=0", {i2c_rw, i2c_reg_addr, i2c_wdata}); end
      checks++; if ({busy, done, error} !== 3'b100) begin failures++; $display("FAIL rst_status got=%b exp=100", {busy, done, error}); end
      checks++; if (err_index !== 4'd0) begin failures++; $display("FAIL rst_err_index got=%0d exp=0", err_index); end
      checks++; if (i2c_slave_addr !== 7'h58) begin failures++; $display("FAIL slave_addr got=%h exp=58", i2c_slave_addr); end
   endtask

   task automatic test_powerup();
      int k;
      bit ok;
      clear_plan();
      nack_left = nk_plan;
      log_q.delete();
      divider_in = 8'd24;
      @(negedge clk);
      reset_n = 1'b1;
      for (k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (k == 5) begin
            checks++; if (busy !== 1'b1) begin failures++; $display("FAIL pwrup_busy got=%b exp=1", busy); end
         end
         if (i2c_req) break;
      end
      checks++; if (k !== 11) begin failures++; $display("FAIL pwrup_first_req_cycle got=%0d exp=11", k); end
      checks++; if (lut_divider !== 8'd24) begin failures++; $display("FAIL pwrup_divider got=%0d exp=24", lut_divider); end
      wait_idle(ok);
      checks++; if (ok !== 1'b1) begin failures++; $display("FAIL pwrup_timeout got=busy exp=idle"); end
      build_expected(8'd24);
      checks++;
      if (log_q.size() !== exp_q.size()) begin
         failures++; $display("FAIL pwrup_log_len got=%0d exp=%0d", log_q.size(), exp_q.size());
      end else begin
         for (int i = 0; i < exp_q.size(); i++) begin
            checks++; if (log_q[i] !== exp_q[i]) begin failures++; $display("FAIL pwrup_xfer%0d got=%h exp=%h", i, log_q[i], exp_q[i]); end
         end
      end
      checks++; if ({busy, done, error} !== 3'b010) begin failures++; $display("FAIL pwrup_status got=%b exp=010", {busy, done, error}); end
   endtask

   task automatic test_start_divider();
      bit         ok;
      logic [7:0] div;
      clear_plan();
      for (int it = 0; it < 3; it++) begin
         div = (it == 0) ? 8'd40 : 8'($urandom_range(0, 255));
         nack_left = nk_plan;
         log_q.delete();
         divider_in = div;
         pulse_start();
         checks++; if (i2c_req !== 1'b0 || lut_divider !== div) begin failures++; $display("FAIL start_load req=%b div=%0d exp req=0 div=%0d", i2c_req, lut_divider, div); end
         @(negedge clk);
         checks++; if (i2c_req !== 1'b1) begin failures++; $display("FAIL start_req_latency got=%b exp=1", i2c_req); end
         wait_idle(ok);
         checks++; if (ok !== 1'b1) begin failures++; $display("FAIL start_timeout got=busy exp=idle"); end
         build_expected(div);
         checks++;
         if (log_q.size() !== exp_q.size()) begin
            failures++; $display("FAIL start_log_len got=%0d exp=%0d", log_q.size(), exp_q.size());
         end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
               checks++; if (log_q[i] !== exp_q[i]) begin failures++; $display("FAIL start_xfer%0d got=%h exp=%h", i, log_q[i], exp_q[i]); end
            end
         end
         checks++; if ({done, error} !== 2'b10) begin failures++; $display("FAIL start_status got=%b exp=10", {done, error}); end
      end
   endtask

   task automatic test_nack_retry();
      bit         ok;
      logic [7:0] div;
      for (int it = 0; it < 3; it++) begin
         clear_plan();
         if (it == 0) nk_plan[2] = 1;
         else nk_plan[$urandom_range(1, 2)] = $urandom_range(0, MAXR);
         nack_left = nk_plan;
         log_q.delete();
         div = 8'($urandom_range(0, 255));
         divider_in = div;
         pulse_start();
         wait_idle(ok);
         checks++; if (ok !== 1'b1) begin failures++; $display("FAIL retry_timeout got=busy exp=idle"); end
         build_expected(div);
         checks++;
         if (log_q.size() !== exp_q.size()) begin
            failures++; $display("FAIL retry_log_len got=%0d exp=%0d", log_q.size(), exp_q.size());
         end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
               checks++; if (log_q[i] !== exp_q[i]) begin failures++; $display("FAIL retry_xfer%0d got=%h exp=%h", i, log_q[i], exp_q[i]); end
            end
         end
         checks++; if ({done, error} !== 2'b10) begin failures++; $display("FAIL retry_status got=%b exp=10", {done, error}); end
      end
   endtask

   task automatic test_nack_fail();
      bit         ok;
      int         e;
      logic [7:0] div;
      for (int it = 0; it < 2; it++) begin
         clear_plan();
         e = (it == 0) ? 1 : $urandom_range(1, 2);
         nk_plan[e] = MAXR + 1 + $urandom_range(0, 2);
         nack_left = nk_plan;
         log_q.delete();
         div = 8'($urandom_range(0, 255));
         divider_in = div;
         pulse_start();
         wait_idle(ok);
         checks++; if (ok !== 1'b1) begin failures++; $display("FAIL fail_timeout got=busy exp=idle"); end
         build_expected(div);
         checks++;
         if (log_q.size() !== exp_q.size()) begin
            failures++; $display("FAIL fail_log_len got=%0d exp=%0d", log_q.size(), exp_q.size());
         end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
               checks++; if (log_q[i] !== exp_q[i]) begin failures++; $display("FAIL fail_xfer%0d got=%h exp=%h", i, log_q[i], exp_q[i]); end
            end
         end
         checks++; if ({done, error} !== 2'b01) begin failures++; $display("FAIL fail_status got=%b exp=01", {done, error}); end
         checks++; if (err_index !== 4'(exp_fail)) begin failures++; $display("FAIL fail_err_index got=%0d exp=%0d", err_index, exp_fail); end
      end
      clear_plan();
      nack_left = nk_plan;
   endtask

   task automatic test_ignore_start();
      bit         ok;
      bit         seen;
      logic [7:0] d1, d2;
      clear_plan();
      nack_left = nk_plan;
      log_q.delete();
      d1 = 8'($urandom_range(0, 255));
      d2 = ~d1;
      divider_in = d1;
      pulse_start();
      checks++; if ({done, error} !== 2'b00 || lut_divider !== d1) begin failures++; $display("FAIL ign_accept status=%b div=%0d exp status=00 div=%0d", {done, error}, lut_divider, d1); end
      seen = 1'b0;
      for (int i = 0; i < 50 && !seen; i++) begin
         @(posedge clk); #1;
         if (i2c_ack) seen = 1'b1;
      end
      checks++; if (seen !== 1'b1) begin failures++; $display("FAIL ign_ack_timeout got=no_ack exp=ack"); end
      // The DUT just took the ack, so this start lands while it waits for completion.
      start = 1'b1;
      divider_in = d2;
      @(negedge clk);
      start = 1'b0;
      repeat (3) begin
         @(negedge clk); start = 1'b1;
         @(negedge clk); start = 1'b0;
      end
      wait_idle(ok);
      checks++; if (ok !== 1'b1) begin failures++; $display("FAIL ign_timeout got=busy exp=idle"); end
      repeat (4) @(negedge clk);
      build_expected(d1);
      checks++;
      if (log_q.size() !== exp_q.size()) begin
         failures++; $display("FAIL ign_log_len got=%0d exp=%0d", log_q.size(), exp_q.size());
      end else begin
         for (int i = 0; i < exp_q.size(); i++) begin
            checks++; if (log_q[i] !== exp_q[i]) begin failures++; $display("FAIL ign_xfer%0d got=%h exp=%h", i, log_q[i], exp_q[i]); end
         end
      end
      checks++; if (lut_divider !== d1 || busy !== 1'b0 || done !== 1'b1) begin failures++; $display("FAIL ign_end div=%0d busy=%b done=%b exp div=%0d busy=0 done=1", lut_divider, busy, done, d1); end
      log_q.delete();
      pulse_start();
      checks++; if (done !== 1'b0 || lut_divider !== d2) begin failures++; $display("FAIL ign_restart done=%b div=%0d exp done=0 div=%0d", done, lut_divider, d2); end
      wait_idle(ok);
      build_expected(d2);
      checks++; if (ok !== 1'b1 || log_q.size() !== exp_q.size() || log_q[1] !== exp_q[1]) begin failures++; $display("FAIL ign_second_pass ok=%b len=%0d exp len=%0d", ok, log_q.size(), exp_q.size()); end
   endtask

   task automatic test_reset_midreq();
      bit         ok;
      bit         seen;
      logic [7:0] d3;
      clear_plan();
      nack_left = nk_plan;
      hold = 1'b1;
      pulse_start();
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge clk);
         if (i2c_req) seen = 1'b1;
      end
      checks++; if (seen !== 1'b1) begin failures++; $display("FAIL rr_req_timeout got=no_req exp=req"); end
      #2;
      reset_n = 1'b0;
      #1;
      checks++; if (i2c_req !== 1'b0) begin failures++; $display("FAIL rr_req_async got=%b exp=0", i2c_req); end
      checks++; if (lut_index !== 4'd0 || busy !== 1'b1) begin failures++; $display("FAIL rr_state idx=%0d busy=%b exp idx=0 busy=1", lut_index, busy); end
      log_q.delete();
      d3 = 8'($urandom_range(0, 255));
      divider_in = d3;
      hold = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      wait_idle(ok);
      checks++; if (ok !== 1'b1) begin failures++; $display("FAIL rr_timeout got=busy exp=idle"); end
      build_expected(d3);
      checks++;
      if (log_q.size() !== exp_q.size()) begin
         failures++; $display("FAIL rr_log_len got=%0d exp=%0d", log_q.size(), exp_q.size());
      end else begin
         for (int i = 0; i < exp_q.size(); i++) begin
            checks++; if (log_q[i] !== exp_q[i]) begin failures++; $display("FAIL rr_xfer%0d got=%h exp=%h", i, log_q[i], exp_q[i]); end
         end
      end
      checks++; if ({done, error} !== 2'b10) begin failures++; $display("FAIL rr_status got=%b exp=10", {done, error}); end
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog got=running exp=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset_n    = 1'b0;
      start      = 1'b0;
      divider_in = 8'd0;
      test_reset();
      test_powerup();
      test_start_divider();
      test_nack_retry();
      test_nack_fail();
      test_ignore_start();
      test_reset_midreq();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
